// File: rtl/des_core_arbiter_if.sv
// Client-side bundle for des_core_arbiter: request/ack and the tagged response port.
// The arbiter uses the slave modport; a client-side driver uses master.
interface des_core_arbiter_if #(
   parameter int unsigned ID_W = 2
);
   localparam int unsigned NUM_REQ = 2**ID_W;

   logic [NUM_REQ-1:0]    req;
   logic [64*NUM_REQ-1:0] req_data;
   logic [64*NUM_REQ-1:0] req_key;
   logic [NUM_REQ-1:0]    ack;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [63:0]           rsp_data;
   logic                  rsp_err;
   logic                  busy;

   modport slave (
      input  req, req_data, req_key, rsp_ready,
      output ack, rsp_valid, rsp_id, rsp_data, rsp_err, busy
   );

   modport master (
      output req, req_data, req_key, rsp_ready,
      input  ack, rsp_valid, rsp_id, rsp_data, rsp_err, busy
   );
endinterface

// File: rtl/des_core_arbiter.sv
// Round-robin sharing of one iterative DES core among 2**ID_W requesters.
// Optional macro DES_ARB_TIMEOUT_EN adds a WAIT-state watchdog that returns an error response.
module des_core_arbiter #(
   parameter int unsigned ID_W        = 2,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   des_core_arbiter_if.slave   cli,
   output logic                core_start,
   output logic [63:0]         core_desIn,
   output logic [63:0]         core_keyIn,
   input  logic                core_ready,
   input  logic [63:0]         core_desOut
);
   localparam int unsigned NUM_REQ = 2**ID_W;

   typedef enum logic [2:0] {StArb, StSetup, StLaunch, StWait, StRelease} state_e;

   state_e               state_q;
   logic [ID_W-1:0]      rr_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic                 rsp_valid_q;
   logic [ID_W-1:0]      rsp_id_q;
   logic [63:0]          rsp_data_q;
   logic                 busy_q;
   logic                 core_start_q;
   logic [63:0]          core_desIn_q;
   logic [63:0]          core_keyIn_q;

   logic [ID_W-1:0]      winner;
   logic [ID_W-1:0]      idx;
   logic [ID_W+5:0]      slice_lo;

`ifdef DES_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   logic [CntW-1:0]      cnt_q;
   logic                 rsp_err_q;
`else
   logic                 unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
`endif

   // Scan downward so the nearest set bit after rr_q overwrites farther ones; rr_q itself is last.
   always_comb begin
      winner = rr_q;
      idx    = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = rr_q + ID_W'(i);
         if (cli.req[idx]) winner = idx;
      end
   end

   assign slice_lo = {winner, 6'd0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StArb;
         rr_q         <= ID_W'(NUM_REQ - 1);
         ack_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         busy_q       <= 1'b0;
         core_start_q <= 1'b0;
         core_desIn_q <= '0;
         core_keyIn_q <= '0;
`ifdef DES_ARB_TIMEOUT_EN
         cnt_q        <= '0;
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         ack_q <= '0;
         unique case (state_q)
            StArb: begin
               if (|cli.req) begin
                  core_desIn_q <= cli.req_data[slice_lo +: 64];
                  core_keyIn_q <= cli.req_key[slice_lo +: 64];
                  rr_q         <= winner;
                  ack_q        <= NUM_REQ'(1) << winner;
                  busy_q       <= 1'b1;
                  state_q      <= StSetup;
               end
            end
            // core_start stays low here so the core latches the new operands.
            StSetup: state_q <= StLaunch;
            StLaunch: begin
               core_start_q <= 1'b1;
               state_q      <= StWait;
`ifdef DES_ARB_TIMEOUT_EN
               cnt_q        <= '0;
`endif
            end
            StWait: begin
               if (core_ready) begin
                  rsp_data_q   <= core_desOut;
                  rsp_id_q     <= rr_q;
                  rsp_valid_q  <= 1'b1;
                  core_start_q <= 1'b0;
                  state_q      <= StRelease;
`ifdef DES_ARB_TIMEOUT_EN
                  rsp_err_q    <= 1'b0;
               end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                  rsp_data_q   <= '0;
                  rsp_id_q     <= rr_q;
                  rsp_valid_q  <= 1'b1;
                  rsp_err_q    <= 1'b1;
                  core_start_q <= 1'b0;
                  state_q      <= StRelease;
               end else begin
                  cnt_q        <= cnt_q + 1'b1;
`endif
               end
            end
            StRelease: begin
               if (rsp_valid_q && cli.rsp_ready) rsp_valid_q <= 1'b0;
               // Leave only once the core has dropped ready and the response is gone.
               if (!core_ready && (!rsp_valid_q || cli.rsp_ready)) begin
                  busy_q  <= 1'b0;
                  state_q <= StArb;
               end
            end
            default: state_q <= StArb;
         endcase
      end
   end

   assign cli.ack       = ack_q;
   assign cli.rsp_valid = rsp_valid_q;
   assign cli.rsp_id    = rsp_id_q;
   assign cli.rsp_data  = rsp_data_q;
   assign cli.busy      = busy_q;
`ifdef DES_ARB_TIMEOUT_EN
   assign cli.rsp_err   = rsp_err_q;
`else
   assign cli.rsp_err   = 1'b0;
`endif
   assign core_start    = core_start_q;
   assign core_desIn    = core_desIn_q;
   assign core_keyIn    = core_keyIn_q;
endmodule

// File: tb/tb_des_core_arbiter.sv
// Directed bench for des_core_arbiter with a stand-in core that follows the start/ready protocol.
// The stand-in returns the FIPS reference ciphertext for the reference vector, a mix otherwise.
module tb_des_core_arbiter;
   localparam int unsigned ID_W = 2;
   localparam int unsigned NUM_REQ = 4;
   localparam int LAT = 3;
   localparam logic [63:0] PT0  = 64'h0123456789ABCDEF;
   localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;
   localparam logic [63:0] CT0  = 64'h85E813540F0AB405;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic core_start, core_ready;
   logic [63:0] core_desIn, core_keyIn, core_desOut;
   int n_checks = 0;
   int n_fail = 0;
   bit core_hang = 1'b0;

   des_core_arbiter_if #(.ID_W(ID_W)) cli ();

   des_core_arbiter #(.ID_W(ID_W), .TIMEOUT_CYC(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cli         (cli),
      .core_start  (core_start),
      .core_desIn  (core_desIn),
      .core_keyIn  (core_keyIn),
      .core_ready  (core_ready),
      .core_desOut (core_desOut)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] core_fn(input logic [63:0] pt, input logic [63:0] key);
      if (pt == PT0 && key == KEY0) return CT0;
      return pt ^ {key[31:0], key[63:32]} ^ 64'hC3C3_5A5A_0FF0_9696;
   endfunction

   // Stand-in core: latches while start is low, answers LAT cycles after start rises.
   logic [63:0] m_pt, m_key;
   logic m_start_d;
   int m_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_ready  <= 1'b0;
         core_desOut <= '0;
         m_start_d   <= 1'b0;
         m_cnt       <= 0;
         m_pt        <= '0;
         m_key       <= '0;
      end else begin
         m_start_d <= core_start;
         if (!core_start) begin
            m_pt       <= core_desIn;
            m_key      <= core_keyIn;
            core_ready <= 1'b0;
            m_cnt      <= 0;
         end else if (!m_start_d) begin
            m_cnt <= LAT;
         end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
         end else if (m_cnt == 1) begin
            m_cnt <= 0;
            if (!core_hang) begin
               core_ready  <= 1'b1;
               core_desOut <= core_fn(m_pt, m_key);
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_all_slices(input logic [63:0] pt, input logic [63:0] key);
      for (int k = 0; k < NUM_REQ; k++) begin
         cli.req_data[64*k +: 64] = pt;
         cli.req_key[64*k +: 64]  = key;
      end
   endtask

   task automatic wait_ack(input string tag, input logic [3:0] exp);
      int n = 0;
      while (cli.ack == '0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 64'(cli.ack), 64'(exp));
      @(negedge clk);
      check_eq({tag, "_pulse"}, 64'(cli.ack), 64'd0);
   endtask

   task automatic wait_rsp(input string tag, input logic [1:0] id, input logic [63:0] data);
      int n = 0;
      while (!cli.rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_valid"}, 64'(cli.rsp_valid), 64'd1);
      check_eq({tag, "_id"}, 64'(cli.rsp_id), 64'(id));
      check_eq({tag, "_data"}, cli.rsp_data, data);
      check_eq({tag, "_err"}, 64'(cli.rsp_err), 64'd0);
   endtask

   task automatic wait_core_start(input string tag);
      int n = 0;
      while (core_start !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 64'(core_start), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] pt_k [NUM_REQ];
      logic [63:0] key_k [NUM_REQ];
      cli.req       = '0;
      cli.rsp_ready = 1'b1;
      set_all_slices(PT0, KEY0);

      // Reset values
      @(negedge clk);
      check_eq("rst_ack", 64'(cli.ack), 64'd0);
      check_eq("rst_valid", 64'(cli.rsp_valid), 64'd0);
      check_eq("rst_id", 64'(cli.rsp_id), 64'd0);
      check_eq("rst_data", cli.rsp_data, 64'd0);
      check_eq("rst_err", 64'(cli.rsp_err), 64'd0);
      check_eq("rst_busy", 64'(cli.busy), 64'd0);
      check_eq("rst_start", 64'(core_start), 64'd0);
      check_eq("rst_desin", core_desIn, 64'd0);
      check_eq("rst_keyin", core_keyIn, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single job from requester 0
      @(negedge clk);
      cli.req = 4'b0001;
      wait_ack("t1_ack", 4'b0001);
      cli.req = '0;
      check_eq("t1_desin", core_desIn, PT0);
      check_eq("t1_keyin", core_keyIn, KEY0);
      check_eq("t1_busy", 64'(cli.busy), 64'd1);
      wait_rsp("t1", 2'd0, CT0);
      @(negedge clk);
      check_eq("t1_consumed", 64'(cli.rsp_valid), 64'd0);

      // All four at once after reset: strict order 0,1,2,3
      do_reset();
      cli.req = 4'b1111;
      for (int k = 0; k < NUM_REQ; k++) begin
         wait_ack($sformatf("t2_ack%0d", k), 4'(1 << k));
         cli.req[k] = 1'b0;
         wait_rsp($sformatf("t2_rsp%0d", k), 2'(k), CT0);
      end

      // Distinct operands per requester: the granted slice must reach the core
      for (int k = 0; k < NUM_REQ; k++) begin
         pt_k[k]  = 64'h1111_1111_1111_1111 * 64'(k + 1);
         key_k[k] = 64'h0F1E_2D3C_4B5A_6978 + 64'(k);
         cli.req_data[64*k +: 64] = pt_k[k];
         cli.req_key[64*k +: 64]  = key_k[k];
      end
      @(negedge clk);
      cli.req = 4'b0110;
      for (int k = 1; k <= 2; k++) begin
         wait_ack($sformatf("t3_ack%0d", k), 4'(1 << k));
         cli.req[k] = 1'b0;
         check_eq($sformatf("t3_desin%0d", k), core_desIn, pt_k[k]);
         wait_rsp($sformatf("t3_rsp%0d", k), 2'(k), core_fn(pt_k[k], key_k[k]));
      end

      // Back-pressure with requester 1 pending
      set_all_slices(PT0, KEY0);
      @(negedge clk);
      cli.rsp_ready = 1'b0;
      cli.req = 4'b0001;
      wait_ack("t4_ack0", 4'b0001);
      cli.req = 4'b0010;
      wait_rsp("t4_rsp0", 2'd0, CT0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("t4_hold_valid", 64'(cli.rsp_valid), 64'd1);
         check_eq("t4_hold_id", 64'(cli.rsp_id), 64'd0);
         check_eq("t4_hold_data", cli.rsp_data, CT0);
         check_eq("t4_no_ack", 64'(cli.ack), 64'd0);
      end
      cli.rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("t4_released", 64'(cli.rsp_valid), 64'd0);
      wait_ack("t4_ack1", 4'b0010);
      cli.req = '0;
      wait_rsp("t4_rsp1", 2'd1, CT0);

      // Reset in WAIT aborts silently
      @(negedge clk);
      cli.req = 4'b0001;
      wait_ack("t5_ack0", 4'b0001);
      cli.req = '0;
      wait_core_start("t5_in_wait");
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_start", 64'(core_start), 64'd0);
      check_eq("t5_rst_busy", 64'(cli.busy), 64'd0);
      check_eq("t5_rst_valid", 64'(cli.rsp_valid), 64'd0);
      check_eq("t5_rst_desin", core_desIn, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check_eq("t5_no_rsp", 64'(cli.rsp_valid), 64'd0);
      end
      cli.req = 4'b0100;
      wait_ack("t5_ack2", 4'b0100);
      cli.req = '0;
      wait_rsp("t5_rsp2", 2'd2, CT0);

      // Fairness: requester 3 held, requester 0 asserted once
      @(negedge clk);
      cli.req = 4'b1000;
      wait_ack("t6_ack3a", 4'b1000);
      cli.req = 4'b1001;
      wait_rsp("t6_rsp3a", 2'd3, CT0);
      wait_ack("t6_ack0", 4'b0001);
      cli.req = 4'b1000;
      wait_rsp("t6_rsp0", 2'd0, CT0);
      wait_ack("t6_ack3b", 4'b1000);
      cli.req = '0;
      wait_rsp("t6_rsp3b", 2'd3, CT0);

`ifdef DES_ARB_TIMEOUT_EN
      // Watchdog with a silent core
      @(negedge clk);
      core_hang = 1'b1;
      cli.req = 4'b0001;
      wait_ack("t7_ack0", 4'b0001);
      cli.req = '0;
      wait_core_start("t7_in_wait");
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         check_eq("t7_not_yet", 64'(cli.rsp_valid), 64'd0);
      end
      @(negedge clk);
      check_eq("t7_valid", 64'(cli.rsp_valid), 64'd1);
      check_eq("t7_err", 64'(cli.rsp_err), 64'd1);
      check_eq("t7_data", cli.rsp_data, 64'd0);
      check_eq("t7_start", 64'(core_start), 64'd0);
      @(negedge clk);
      core_hang = 1'b0;
      check_eq("t7_consumed", 64'(cli.rsp_valid), 64'd0);
`endif

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
